// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Round-robin arbiter that shares a single UART Tx module among NUM_REQ
// requesters. One character is in flight at a time. The winner's data and
// config are captured at grant time and held on tx_data_o/tx_conf_o until the
// Tx module reports completion, so requesters may change their inputs as soon
// as they see their req_ready_o pulse.
//
// Character lifecycle (all outputs registered):
//   IDLE   -> grant: req_ready_o pulse, tx_start_o=1, busy_o=1
//   START  -> hold tx_start_o until tx_busy_i is sampled high
//   WAIT   -> wait for a rising edge on tx_done_i
//   FINISH -> one-cycle done_o pulse, round-robin pointer advances
//
// Ports:
//   clk_i        single clock
//   rst_ni       asynchronous active-low reset
//   arb_en_i     permit new grants (an in-flight character always completes)
//   req_valid_i  [NUM_REQ]                   per-requester pending character
//   req_data_i   [NUM_REQ*MAX_UART_DATA_W]   packed data, requester k at slice k
//   req_conf_i   [NUM_REQ*TOTAL_CONF_W]      packed config, requester k at slice k
//   req_ready_o  [NUM_REQ]                   one-cycle onehot accept pulse
//   tx_start_o                               start request to the Tx module
//   tx_data_o    [MAX_UART_DATA_W]           data to the Tx module
//   tx_conf_o    [TOTAL_CONF_W]              {data[1:0], stop[1:0], parity_en}
//   tx_busy_i                                Tx module busy
//   tx_done_i                                Tx module done (level, one baud tick)
//   grant_idx_o  [REQ_IDX_W]                 index of current or last grant
//   busy_o                                   arbiter owns the Tx module
//   done_o                                   one-cycle pulse at completion
//   done_idx_o   [REQ_IDX_W]                 requester index valid with done_o
// -----------------------------------------------------------------------------
module tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int REQ_IDX_W       = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 arb_en_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ*MAX_UART_DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ*TOTAL_CONF_W-1:0]      req_conf_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic                                 tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]           tx_data_o,
  output logic [TOTAL_CONF_W-1:0]              tx_conf_o,
  input  logic                                 tx_busy_i,
  input  logic                                 tx_done_i,
  output logic [REQ_IDX_W-1:0]                 grant_idx_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [REQ_IDX_W-1:0]                 done_idx_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [REQ_IDX_W-1:0] LAST_IDX_RST = REQ_IDX_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------------
  // Round-robin pick: first asserted requester scanning upward from last+1,
  // wrapping at NUM_REQ. The returned value is only used when valid is nonzero.
  // ---------------------------------------------------------------------------
  function automatic logic [REQ_IDX_W-1:0] pick_winner(
    input logic [NUM_REQ-1:0]   valid,
    input logic [REQ_IDX_W-1:0] last
  );
    logic [REQ_IDX_W-1:0] win;
    logic [REQ_IDX_W-1:0] cand;
    logic                 found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand  = REQ_IDX_W'((int'(last) + k) % NUM_REQ);
      win   = (!found && valid[cand]) ? cand : win;
      found = found | valid[cand];
    end
    return win;
  endfunction

  state_t                      state;
  state_t                      state_nxt;
  logic [REQ_IDX_W-1:0]        last_idx;
  logic [REQ_IDX_W-1:0]        last_idx_nxt;
  logic                        tx_done_q;
  logic                        done_rise;
  logic [REQ_IDX_W-1:0]        winner;

  logic [NUM_REQ-1:0]          req_ready_nxt;
  logic                        tx_start_nxt;
  logic [MAX_UART_DATA_W-1:0]  tx_data_nxt;
  logic [TOTAL_CONF_W-1:0]     tx_conf_nxt;
  logic [REQ_IDX_W-1:0]        grant_idx_nxt;
  logic                        busy_nxt;
  logic                        done_nxt;
  logic [REQ_IDX_W-1:0]        done_idx_nxt;

  assign winner    = pick_winner(req_valid_i, last_idx);
  // A held-high done level is one completion: only the 0->1 transition counts.
  assign done_rise = tx_done_i & ~tx_done_q;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_nxt     = state;
    last_idx_nxt  = last_idx;
    req_ready_nxt = {NUM_REQ{1'b0}};
    tx_start_nxt  = tx_start_o;
    tx_data_nxt   = tx_data_o;
    tx_conf_nxt   = tx_conf_o;
    grant_idx_nxt = grant_idx_o;
    busy_nxt      = busy_o;
    done_nxt      = 1'b0;
    done_idx_nxt  = done_idx_o;

    case (state)
      IDLE: begin
        if (arb_en_i && (req_valid_i != {NUM_REQ{1'b0}})) begin
          // Capture the winner's character now; it is held until FINISH.
          state_nxt             = START;
          req_ready_nxt[winner] = 1'b1;
          tx_start_nxt          = 1'b1;
          busy_nxt              = 1'b1;
          grant_idx_nxt         = winner;
          tx_data_nxt           = req_data_i[int'(winner)*MAX_UART_DATA_W +: MAX_UART_DATA_W];
          tx_conf_nxt           = req_conf_i[int'(winner)*TOTAL_CONF_W +: TOTAL_CONF_W];
        end else begin
          tx_start_nxt = 1'b0;
          busy_nxt     = 1'b0;
        end
      end

      START: begin
        // No timeout: the Tx module may only react on a slow baud tick.
        if (tx_busy_i) begin
          tx_start_nxt = 1'b0;
          state_nxt    = WAIT;
        end else begin
          tx_start_nxt = 1'b1;
        end
      end

      WAIT: begin
        if (done_rise) begin
          state_nxt    = FINISH;
          done_nxt     = 1'b1;
          done_idx_nxt = grant_idx_o;
          busy_nxt     = 1'b0;
        end else begin
          state_nxt = WAIT;
        end
      end

      FINISH: begin
        // Pointer advances only once the character is complete; no grant here,
        // which guarantees at least one IDLE cycle before the next grant.
        last_idx_nxt = grant_idx_o;
        state_nxt    = IDLE;
      end

      default: begin
        state_nxt    = IDLE;
        tx_start_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // State, round-robin pointer and done-edge history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      last_idx  <= LAST_IDX_RST;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_idx  <= last_idx_nxt;
      tx_done_q <= tx_done_i;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_o <= {NUM_REQ{1'b0}};
      tx_start_o  <= 1'b0;
      tx_data_o   <= {MAX_UART_DATA_W{1'b0}};
      tx_conf_o   <= {TOTAL_CONF_W{1'b0}};
      grant_idx_o <= {REQ_IDX_W{1'b0}};
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      done_idx_o  <= {REQ_IDX_W{1'b0}};
    end else begin
      req_ready_o <= req_ready_nxt;
      tx_start_o  <= tx_start_nxt;
      tx_data_o   <= tx_data_nxt;
      tx_conf_o   <= tx_conf_nxt;
      grant_idx_o <= grant_idx_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
      done_idx_o  <= done_idx_nxt;
    end
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter MAX_UART_DATA_W, default 8, SHALL set the per-requester data width.
REQ-003 Parameter TOTAL_CONF_W, default 5, SHALL set the per-requester config width, {data[1:0], stop[1:0], parity_en}.
REQ-004 Parameter REQ_IDX_W, default 2, SHALL set the index width, equal to clog2(NUM_REQ).
REQ-005 Ports SHALL be, one per line:
 clk_i  in  1  single clock
 rst_ni  in  1  asynchronous active-low reset
 arb_en_i  in  1  permit new grants
 req_valid_i  in  NUM_REQ  per-requester pending character
 req_data_i  in  NUM_REQ*MAX_UART_DATA_W  packed data, requester k at slice k
 req_conf_i  in  NUM_REQ*TOTAL_CONF_W  packed config, requester k at slice k
 req_ready_o  out  NUM_REQ  one-cycle accept pulse, onehot
 tx_start_o  out  1  start request to Tx module
 tx_data_o  out  MAX_UART_DATA_W  data to Tx module
 tx_conf_o  out  TOTAL_CONF_W  config to Tx module
 tx_busy_i  in  1  Tx module busy
 tx_done_i  in  1  Tx module done, level held for one baud tick
 grant_idx_o  out  REQ_IDX_W  index of current or last grant
 busy_o  out  1  arbiter owns Tx module
 done_o  out  1  one-cycle pulse at character completion
 done_idx_o  out  REQ_IDX_W  requester index valid with done_o

Function
REQ-006 FSM states SHALL be IDLE, START, WAIT and FINISH, with all outputs registered.
REQ-007 IDLE: when arb_en_i=1 and req_valid_i is nonzero, the block SHALL select winner w, latch its data/conf into tx_data_o/tx_conf_o, set grant_idx_o=w, pulse req_ready_o[w], set tx_start_o=1 and busy_o=1, and go to START on the next edge.
REQ-008 Winner SHALL be the first asserted requester scanning (last_idx+1) mod NUM_REQ upward with wrap; last_idx SHALL update to w only at FINISH.
REQ-009 Grant latency SHALL be 1 cycle: valid sampled at edge N gives req_ready_o and tx_start_o high after edge N+1.
REQ-010 START: tx_start_o SHALL stay 1 until tx_busy_i=1 is sampled, then go 0 and the FSM SHALL go to WAIT; there is no timeout, which covers slow baud_en ticks.
REQ-011 WAIT: on a tx_done_i rising edge (registered previous value 0, current 1) the FSM SHALL go to FINISH; a held-high tx_done_i SHALL count as exactly one completion.
REQ-012 FINISH (one cycle): done_o=1, done_idx_o=grant_idx_o, busy_o=0, last_idx=grant_idx_o, then IDLE; no grant SHALL be issued in the FINISH cycle.
REQ-013 tx_data_o and tx_conf_o SHALL remain stable from grant through FINISH.
REQ-014 req_valid_i/req_data_i/req_conf_i changes after acceptance SHALL NOT affect the in-flight character.
REQ-015 arb_en_i=0 SHALL block new grants only; an in-flight character SHALL complete normally.
REQ-016 A single requester held valid SHALL be re-granted back-to-back, with a minimum of 1 IDLE cycle between FINISH and the next grant.
REQ-017 A tx_done_i edge outside WAIT SHALL be ignored, with no done_o.
REQ-018 Unused/illegal FSM encodings SHALL return to IDLE with tx_start_o=0.

Reset
REQ-019 rst_ni=0 SHALL immediately and asynchronously force state=IDLE, last_idx=NUM_REQ-1, and tx_start_o, req_ready_o, busy_o, done_o, grant_idx_o, done_idx_o, tx_data_o and tx_conf_o to 0.
REQ-020 Reset mid-transfer SHALL abandon the character with no done_o, and the pending request SHALL NOT be re-accepted automatically; the requester re-asserts.
REQ-021 After rst_ni deasserts, the first grant SHALL occur no earlier than the first clk_i edge with rst_ni=1, and requester 0 SHALL have top priority.

Verification
REQ-022 Reset, then req_valid_i=4'b0001 with data 8'hA5 and conf 5'b11_00_1 -> req_ready_o=0001 for 1 cycle, tx_start_o held until tx_busy_i, tx_data_o=A5; tx_done_i high for 16 cycles -> one done_o pulse with done_idx_o=0.
REQ-023 req_valid_i=4'b1111 held for 4 characters -> grant order 0,1,2,3, then 0 again on the 5th.
REQ-024 Last grant=2, req_valid_i=4'b0101 -> next grant is 0, the wrap case.
REQ-025 arb_en_i dropped during WAIT -> current character still completes with done_o; no new grant until arb_en_i=1.
REQ-026 rst_ni pulsed low during WAIT -> all outputs 0 within the same cycle; a later tx_done_i produces no done_o.
REQ-027 tx_busy_i delayed 40 cycles after grant -> tx_start_o high for all 40 cycles and tx_data_o unchanged.
